// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder; the building block of the serial adder's ripple slice.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit adder/subtractor that ripples BITS_PER_CYCLE bits per clock through
// a slice of full adders, with a registered carry between chunks.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned BPC = BITS_PER_CYCLE;
  localparam int unsigned N   = WIDTH / BPC;
  localparam int unsigned CW  = cnt_width(N);

  if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BPC:0]         c;
  logic [BPC-1:0]       s;
  logic [WIDTH+BPC-1:0] res_cat;
  logic [WIDTH-1:0]     res_shift;
  logic                 last_chunk;

  assign c[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_slice
    full_adder_1b u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  // Partial results build up in res_q; the visible sum only updates on the
  // final chunk so it stays stable for the whole RUN phase.
  assign res_cat    = {s, res_q};
  assign res_shift  = res_cat[WIDTH+BPC-1:BPC];
  assign last_chunk = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          res_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        res_d   = res_shift;
        carry_d = c[BPC];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = c[BPC];
          ovf_d   = c[BPC] ^ c[BPC-1];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: three serial_adder configurations checked against an
// arithmetic reference model, plus handshake, latency and reset-abort checks.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 0, cin0 = 0, sub0 = 0, busy0, done0, cout0, ovf0;
  logic [7:0] a0 = '0, b0 = '0, sum0;
  logic       start1 = 0, cin1 = 0, sub1 = 0, busy1, done1, cout1, ovf1;
  logic [3:0] a1 = '0, b1 = '0, sum1;
  logic       start2 = 0, cin2 = 0, sub2 = 0, busy2, done2, cout2, ovf2;
  logic [3:0] a2 = '0, b2 = '0, sum2;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0));
  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));

  int n_tests = 0;
  int n_fail  = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packed as {overflow, cout, sum}; derived from two's-complement arithmetic.
  function automatic int ref_model(input int w, input int a, input int b,
                                   input int cin, input int sub);
    int mask = (1 << w) - 1;
    int sgn  = 1 << (w - 1);
    int r, co, ov;
    if (sub == 0) begin
      r  = a + b + cin;
      co = (r >> w) & 1;
      r  = r & mask;
      ov = ((a & sgn) == (b & sgn)) && ((r & sgn) != (a & sgn));
    end else begin
      r  = (a - b) & mask;
      co = (a >= b) ? 1 : 0;
      ov = ((a & sgn) != (b & sgn)) && ((r & sgn) != (a & sgn));
    end
    return (ov << (w + 1)) | (co << w) | r;
  endfunction

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (done0) begin
        if (q0.size() == 0) chk("unexpected_done0", 1, 0);
        else begin e = q0.pop_front(); chk("result_w8b1", int'({ovf0, cout0, sum0}), e); end
      end
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin e = q1.pop_front(); chk("result_w4b2", int'({ovf1, cout1, sum1}), e); end
      end
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done2", 1, 0);
        else begin e = q2.pop_front(); chk("result_w4b4", int'({ovf2, cout2, sum2}), e); end
      end
    end
  end

  task automatic drive(input int d, input int s, input int a, input int b,
                       input int cin, input int sub);
    case (d)
      0: begin start0 = s[0]; a0 = a[7:0]; b0 = b[7:0]; cin0 = cin[0]; sub0 = sub[0]; end
      1: begin start1 = s[0]; a1 = a[3:0]; b1 = b[3:0]; cin1 = cin[0]; sub1 = sub[0]; end
      default: begin start2 = s[0]; a2 = a[3:0]; b2 = b[3:0]; cin2 = cin[0]; sub2 = sub[0]; end
    endcase
  endtask

  task automatic drop_start(input int d);
    case (d)
      0: start0 = 1'b0;
      1: start1 = 1'b0;
      default: start2 = 1'b0;
    endcase
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? done0 : (d == 1) ? done1 : done2;
  endfunction

  // Called #1 after a rising edge; returns the same way, DUT back in IDLE.
  task automatic run_op(input int d, input int a, input int b, input int cin, input int sub);
    int w    = (d == 0) ? 8 : 4;
    int nch  = (d == 0) ? 8 : (d == 1) ? 2 : 1;
    int e    = ref_model(w, a, b, cin, sub);
    int lat  = 0;
    bit got  = 0;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    drive(d, 1, a, b, cin, sub);
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        drop_start(d);
        chk("busy_after_accept", int'(get_busy(d)), 1);
      end
      if (get_done(d)) got = 1;
    end
    chk("done_latency", got ? lat : -1, nch + 1);
    @(posedge clk); #1;
    chk("done_pulse_width", int'({get_busy(d), get_done(d)}), 0);
  endtask

  initial begin
    int ra, rb;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state0", int'({busy0, done0, sum0, cout0, ovf0}), 0);
    chk("reset_state12", int'({busy1, done1, busy2, done2}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 8'h00, 8'h00, 0, 0);
    run_op(0, 8'hFF, 8'h01, 0, 0);
    run_op(0, 8'h7F, 8'h01, 1, 0);
    run_op(0, 8'h05, 8'h07, 1, 1);
    run_op(0, 8'h80, 8'h01, 1, 1);

    // start while running must be ignored; sum cleared at acceptance and held
    q0.push_back(ref_model(8, 8'h10, 8'h20, 0, 0));
    drive(0, 1, 8'h10, 8'h20, 0, 0);
    @(posedge clk); #1;
    drop_start(0);
    repeat (3) @(posedge clk);
    #1;
    chk("sum_held_during_run", int'(sum0), 0);
    drive(0, 1, 8'hFF, 8'hFF, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    drop_start(0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (done0) got = 1;
    end
    chk("ignored_start_done", int'(got), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("ignored_start_sum", int'(sum0), 8'h30);

    // reset mid-RUN aborts without a done pulse
    drive(0, 1, 8'h33, 8'h11, 0, 0);
    @(posedge clk); #1;
    drop_start(0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", int'({busy0, done0, sum0, cout0, ovf0}), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", int'(done0), 0);
    run_op(0, 8'h0A, 8'h05, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run_op(0, ra, rb, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    for (int d = 1; d <= 2; d++)
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < 2; c++)
          for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
              run_op(d, x, y, c, s);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
